// File: rtl/kyber_bram_dma.sv
// BRAM-to-core DMA sequencer: streams rd_len words into the core, starts it, then
// stores wr_len result words back to the output BRAM.
module kyber_bram_dma #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8,
    parameter int RD_LAT = 1,
    parameter int TO_CYC = 0
) (
    input  logic                  reg_clk,
    input  logic                  reg_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     rd_base,
    input  logic [CNT_W-1:0]      rd_len,
    input  logic [ADDR_W-1:0]     wr_base,
    input  logic [CNT_W-1:0]      wr_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     in_addr,
    output logic                  in_en,
    input  logic [DATA_W-1:0]     in_rddata,
    output logic                  ld_valid,
    output logic [CNT_W-1:0]      ld_idx,
    output logic [DATA_W-1:0]     ld_data,
    output logic                  core_start,
    input  logic                  core_finish,
    output logic [CNT_W-1:0]      st_idx,
    input  logic [DATA_W-1:0]     st_data,
    output logic [ADDR_W-1:0]     out_addr,
    output logic                  out_en,
    output logic [DATA_W/8-1:0]   out_we,
    output logic [DATA_W-1:0]     out_wrdata
);

    localparam int WD_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'((TO_CYC > 0) ? TO_CYC - 1 : 0);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, PROC, WRITE, FIN} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] rd_base_r, wr_base_r;
    logic [CNT_W-1:0]  rd_len_r, wr_len_r;
    logic [CNT_W-1:0]  k_cnt, j_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [RD_LAT-1:0] vpipe;
    logic [CNT_W-1:0]  ipipe [RD_LAT];
    logic              wd_expire;

    assign wd_expire = (TO_CYC != 0) && (wd_cnt == WD_LIM);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN) && !abort;
    assign st_idx    = j_cnt;
    assign ld_valid  = vpipe[RD_LAT-1];
    assign ld_idx    = ipipe[RD_LAT-1];
    assign ld_data   = ld_valid ? in_rddata : '0;

    always_ff @(posedge reg_clk) begin
        if (reg_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (rd_len == '0) ? DRAIN : READ;
            READ:  if (k_cnt == rd_len_r - CNT_W'(1)) state_nx = DRAIN;
            DRAIN: if (vpipe == '0) state_nx = PROC;
            PROC: begin
                if (core_finish)    state_nx = (wr_len_r == '0) ? FIN : WRITE;
                else if (wd_expire) state_nx = IDLE;
            end
            WRITE: if (j_cnt == wr_len_r - CNT_W'(1)) state_nx = FIN;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE) state_nx = IDLE;
    end

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            rd_base_r  <= '0;
            wr_base_r  <= '0;
            rd_len_r   <= '0;
            wr_len_r   <= '0;
            k_cnt      <= '0;
            j_cnt      <= '0;
            wd_cnt     <= '0;
            vpipe      <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) ipipe[i] <= '0;
            err        <= 1'b0;
            in_en      <= 1'b0;
            in_addr    <= '0;
            core_start <= 1'b0;
            out_en     <= 1'b0;
            out_we     <= '0;
            out_addr   <= '0;
            out_wrdata <= '0;
        end else begin
            in_en      <= 1'b0;
            out_en     <= 1'b0;
            out_we     <= '0;
            core_start <= 1'b0;
            // Each issue's valid/index travels alongside the BRAM's own read latency.
            vpipe[0]   <= in_en;
            ipipe[0]   <= k_cnt;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                ipipe[i] <= ipipe[i-1];
            end
            case (state)
                IDLE: if (start) begin
                    rd_base_r <= rd_base;
                    rd_len_r  <= rd_len;
                    wr_base_r <= wr_base;
                    wr_len_r  <= wr_len;
                    err       <= 1'b0;
                    k_cnt     <= '0;
                    j_cnt     <= '0;
                    if (rd_len != '0) begin
                        in_en   <= 1'b1;
                        in_addr <= rd_base;
                    end
                end
                READ: if (state_nx == READ) begin
                    k_cnt   <= k_cnt + CNT_W'(1);
                    in_en   <= 1'b1;
                    in_addr <= rd_base_r + ADDR_W'(k_cnt + CNT_W'(1));
                end
                DRAIN: if (state_nx == PROC) begin
                    core_start <= 1'b1;
                    wd_cnt     <= '0;
                end
                PROC: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (state_nx == IDLE) err <= 1'b1;
                end
                WRITE: begin
                    out_en     <= 1'b1;
                    out_we     <= '1;
                    out_addr   <= wr_base_r + ADDR_W'(j_cnt);
                    out_wrdata <= st_data;
                    j_cnt      <= (state_nx == WRITE) ? j_cnt + CNT_W'(1) : '0;
                end
                default: ;
            endcase
            if (abort && state != IDLE) begin
                in_en      <= 1'b0;
                out_en     <= 1'b0;
                out_we     <= '0;
                core_start <= 1'b0;
                vpipe      <= '0;
                j_cnt      <= '0;
                err        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kyber_bram_dma.sv
// Directed bench for kyber_bram_dma: BRAM/core models plus expected-word queues
// drained as the DUT emits reads, load words and writes.
module tb_kyber_bram_dma;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 8;
    localparam int RD_LAT = 3;
    localparam int TO_CYC = 16;

    logic                reg_clk = 1'b0;
    logic                reg_rst = 1'b1;
    logic                start = 1'b0, abort = 1'b0, core_finish = 1'b0;
    logic [ADDR_W-1:0]   rd_base = '0, wr_base = '0;
    logic [CNT_W-1:0]    rd_len = '0, wr_len = '0;
    logic                busy, done, err, in_en, ld_valid, core_start, out_en;
    logic [ADDR_W-1:0]   in_addr, out_addr;
    logic [DATA_W-1:0]   in_rddata, ld_data, st_data, out_wrdata;
    logic [CNT_W-1:0]    ld_idx, st_idx;
    logic [DATA_W/8-1:0] out_we;

    kyber_bram_dma #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
                     .RD_LAT(RD_LAT), .TO_CYC(TO_CYC)) u_dut (
        .reg_clk(reg_clk), .reg_rst(reg_rst), .start(start), .abort(abort),
        .rd_base(rd_base), .rd_len(rd_len), .wr_base(wr_base), .wr_len(wr_len),
        .busy(busy), .done(done), .err(err), .in_addr(in_addr), .in_en(in_en),
        .in_rddata(in_rddata), .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data),
        .core_start(core_start), .core_finish(core_finish), .st_idx(st_idx),
        .st_data(st_data), .out_addr(out_addr), .out_en(out_en), .out_we(out_we),
        .out_wrdata(out_wrdata)
    );

    always #5 reg_clk = ~reg_clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {a, ~a, 8'h5A, a ^ 8'h3C};
    endfunction
    function automatic logic [31:0] core_word(input logic [7:0] i);
        return {8'hC3, i, ~i, 8'h11};
    endfunction

    logic [DATA_W-1:0] rdp [RD_LAT];
    always @(posedge reg_clk) begin
        rdp[0] <= in_en ? mem_word(in_addr) : 32'hDEAD_BEEF;
        for (int i = 1; i < RD_LAT; i++) rdp[i] <= rdp[i-1];
    end
    assign in_rddata = rdp[RD_LAT-1];
    assign st_data   = core_word(st_idx);

    int n_tests = 0, n_fail = 0, cyc = 0;
    int n_inen, n_ld, n_outen, n_cs, n_done, first_inen, first_ld, last_ld, cs_cyc;
    logic [7:0]  q_rd [$];
    logic [39:0] q_ld [$];
    logic [39:0] q_wr [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_inen = 0; n_ld = 0; n_outen = 0; n_cs = 0; n_done = 0;
        first_inen = 0; first_ld = 0; last_ld = 0; cs_cyc = 0;
    endtask

    // Advance to the next falling edge and score whatever the DUT is presenting.
    task automatic tick();
        logic [39:0] e;
        @(negedge reg_clk);
        cyc++;
        if (in_en) begin
            n_inen++;
            if (n_inen == 1) first_inen = cyc;
            if (q_rd.size() == 0) chk("in_en_unexpected", 64'(in_en), 64'(0));
            else chk("in_addr", 64'(in_addr), 64'(q_rd.pop_front()));
        end
        if (ld_valid) begin
            n_ld++;
            if (n_ld == 1) first_ld = cyc;
            last_ld = cyc;
            if (q_ld.size() == 0) chk("ld_valid_unexpected", 64'(ld_valid), 64'(0));
            else begin
                e = q_ld.pop_front();
                chk("ld_idx", 64'(ld_idx), 64'(e[39:32]));
                chk("ld_data", 64'(ld_data), 64'(e[31:0]));
            end
        end
        if (out_en) begin
            n_outen++;
            if (q_wr.size() == 0) chk("out_en_unexpected", 64'(out_en), 64'(0));
            else begin
                e = q_wr.pop_front();
                chk("out_addr", 64'(out_addr), 64'(e[39:32]));
                chk("out_wrdata", 64'(out_wrdata), 64'(e[31:0]));
                chk("out_we", 64'(out_we), 64'(4'hF));
            end
        end
        if (core_start) begin n_cs++; cs_cyc = cyc; end
        if (done) n_done++;
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_busy"}, 64'(busy), 64'(0));
        chk({pfx, "_done"}, 64'(done), 64'(0));
        chk({pfx, "_err"}, 64'(err), 64'(0));
        chk({pfx, "_in_en"}, 64'(in_en), 64'(0));
        chk({pfx, "_in_addr"}, 64'(in_addr), 64'(0));
        chk({pfx, "_ld_valid"}, 64'(ld_valid), 64'(0));
        chk({pfx, "_ld_idx"}, 64'(ld_idx), 64'(0));
        chk({pfx, "_ld_data"}, 64'(ld_data), 64'(0));
        chk({pfx, "_core_start"}, 64'(core_start), 64'(0));
        chk({pfx, "_st_idx"}, 64'(st_idx), 64'(0));
        chk({pfx, "_out_en"}, 64'(out_en), 64'(0));
        chk({pfx, "_out_we"}, 64'(out_we), 64'(0));
        chk({pfx, "_out_addr"}, 64'(out_addr), 64'(0));
        chk({pfx, "_out_wrdata"}, 64'(out_wrdata), 64'(0));
    endtask

    task automatic start_txn(input logic [7:0] rb, input logic [7:0] rl, input logic [7:0] wb,
                             input logic [7:0] wl, input int n_rd_exp, input int n_wr_exp,
                             input logic with_abort);
        logic [7:0] a;
        for (int k = 0; k < n_rd_exp; k++) begin
            a = rb + 8'(k);
            q_rd.push_back(a);
            q_ld.push_back({8'(k), mem_word(a)});
        end
        for (int j = 0; j < n_wr_exp; j++) q_wr.push_back({wb + 8'(j), core_word(8'(j))});
        clear_stats();
        rd_base = rb; rd_len = rl; wr_base = wb; wr_len = wl;
        start = 1'b1; abort = with_abort;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("err_cleared_on_start", 64'(err), 64'(0));
    endtask

    task automatic wait_cs();
        for (int i = 0; i < 1000 && n_cs == 0; i++) tick();
        chk("core_start_pulses", 64'(n_cs), 64'(1));
    endtask

    task automatic finish_core(input int dly);
        repeat (dly) tick();
        core_finish = 1'b1;
        tick();
        core_finish = 1'b0;
    endtask

    task automatic end_txn(input int exp_done, input logic exp_err, input int exp_inen,
                           input int exp_outen, input int rl_full);
        for (int i = 0; i < 2000 && busy; i++) tick();
        chk("idle_reached", 64'(busy), 64'(0));
        chk("done_count", 64'(n_done), 64'(exp_done));
        chk("err_flag", 64'(err), 64'(exp_err));
        chk("in_en_count", 64'(n_inen), 64'(exp_inen));
        chk("out_en_count", 64'(n_outen), 64'(exp_outen));
        chk("rd_left", 64'(q_rd.size()), 64'(0));
        chk("ld_left", 64'(q_ld.size()), 64'(0));
        chk("wr_left", 64'(q_wr.size()), 64'(0));
        if (rl_full > 0) begin
            chk("ld_count", 64'(n_ld), 64'(rl_full));
            chk("ld_latency", 64'(first_ld - first_inen), 64'(RD_LAT));
            chk("core_start_after_ld", 64'(cs_cyc > last_ld), 64'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        clear_stats();
        repeat (3) tick();
        chk_outputs_zero("rst");
        reg_rst = 1'b0;
        tick();

        // Basic load / process / store with distinct lengths.
        start_txn(8'd52, 8'd2, 8'd102, 8'd3, 2, 3, 1'b0);
        wait_cs();
        finish_core(10);
        end_txn(1, 1'b0, 2, 3, 2);

        start_txn(8'd10, 8'd4, 8'd40, 8'd1, 4, 1, 1'b0);
        wait_cs();
        finish_core(1);
        end_txn(1, 1'b0, 4, 1, 4);

        // Address wrap on both sides, plus a second start while busy that must be ignored.
        start_txn(8'd254, 8'd4, 8'd253, 8'd5, 4, 5, 1'b0);
        tick();
        rd_base = 8'd0; rd_len = 8'd9; wr_len = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_cs();
        finish_core(3);
        end_txn(1, 1'b0, 4, 5, 4);

        // Zero-length transfer: core still started, no BRAM traffic.
        start_txn(8'd7, 8'd0, 8'd9, 8'd0, 0, 0, 1'b0);
        wait_cs();
        finish_core(2);
        end_txn(1, 1'b0, 0, 0, 0);

        // Abort during WRITE once st_idx reaches 1.
        start_txn(8'd20, 8'd3, 8'd200, 8'd4, 3, 1, 1'b0);
        wait_cs();
        finish_core(2);
        for (int i = 0; i < 50 && st_idx != 8'd1; i++) tick();
        chk("abort_st_idx", 64'(st_idx), 64'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_out_en", 64'(out_en), 64'(0));
        chk("abort_err", 64'(err), 64'(1));
        end_txn(0, 1'b1, 3, 1, 3);

        // Start with abort in IDLE: starts, clears err.
        start_txn(8'd100, 8'd1, 8'd50, 8'd2, 1, 2, 1'b1);
        wait_cs();
        finish_core(4);
        end_txn(1, 1'b0, 1, 2, 1);

        // Watchdog: no core_finish, expires after TO_CYC PROC cycles.
        start_txn(8'd30, 8'd1, 8'd31, 8'd2, 1, 0, 1'b0);
        wait_cs();
        repeat (TO_CYC - 1) tick();
        chk("wd_busy_last_proc", 64'(busy), 64'(1));
        tick();
        chk("wd_busy", 64'(busy), 64'(0));
        chk("wd_err", 64'(err), 64'(1));
        end_txn(0, 1'b1, 1, 0, 1);

        // Abort and core_finish together in PROC: abort wins.
        start_txn(8'd60, 8'd2, 8'd61, 8'd2, 2, 0, 1'b0);
        wait_cs();
        tick();
        abort = 1'b1; core_finish = 1'b1;
        tick();
        abort = 1'b0; core_finish = 1'b0;
        chk("abort_fin_busy", 64'(busy), 64'(0));
        repeat (3) tick();
        end_txn(0, 1'b1, 2, 0, 2);

        // Reset mid-READ discards the transaction.
        start_txn(8'd5, 8'd6, 8'd6, 8'd2, 6, 0, 1'b0);
        repeat (2) tick();
        reg_rst = 1'b1;
        tick();
        reg_rst = 1'b0;
        chk_outputs_zero("midrst");
        q_rd.delete(); q_ld.delete(); q_wr.delete();
        repeat (5) tick();
        chk("midrst_no_done", 64'(n_done), 64'(0));
        chk("midrst_idle", 64'(busy), 64'(0));

        // Maximum length in both directions.
        start_txn(8'd3, 8'd255, 8'd250, 8'd255, 255, 255, 1'b0);
        wait_cs();
        finish_core(2);
        end_txn(1, 1'b0, 255, 255, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kyber_bram_dma.md
KYBER_BRAM_DMA -- requirements
Module: kyber_bram_dma

Interface
REQ-001 SHALL have parameter DATA_W, default 128: BRAM word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 8: BRAM address width.
REQ-003 SHALL have parameter CNT_W, default 8: word-count and index width.
REQ-004 SHALL have parameter RD_LAT, default 1: input BRAM read latency in cycles; legal values 1..3.
REQ-005 SHALL have parameter TO_CYC, default 0: PROC watchdog limit in cycles; 0 disables the watchdog.
REQ-006 SHALL use one clock and a synchronous, active-high reset:
- reg_clk  in  1  clock; all logic on its rising edge.
- reg_rst  in  1  synchronous active-high reset.
REQ-007 SHALL have these control ports:
- start  in  1  one-cycle request pulse.
- abort  in  1  cancels the current transaction.
- rd_base  in  ADDR_W  input BRAM base address.
- rd_len  in  CNT_W  number of words to load.
- wr_base  in  ADDR_W  output BRAM base address.
- wr_len  in  CNT_W  number of words to store.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky abort/timeout flag.
REQ-008 SHALL have these input-BRAM ports:
- in_addr  out  ADDR_W.
- in_en  out  1.
- in_rddata  in  DATA_W.
REQ-009 SHALL have these core ports:
- ld_valid  out  1  load word valid.
- ld_idx  out  CNT_W  load word index.
- ld_data  out  DATA_W  load word data.
- core_start  out  1  one-cycle start pulse.
- core_finish  in  1  core has finished.
- st_idx  out  CNT_W  index of the word to store.
- st_data  in  DATA_W  word supplied combinationally by the core for st_idx.
REQ-010 SHALL have these output-BRAM ports:
- out_addr  out  ADDR_W.
- out_en  out  1.
- out_we  out  DATA_W/8.
- out_wrdata  out  DATA_W.

Function
REQ-011 SHALL implement states IDLE, READ, DRAIN, PROC, WRITE, FIN.
REQ-012 In IDLE, a start pulse SHALL latch all four base/len inputs, clear err, and move to READ; if rd_len==0 it SHALL move to DRAIN instead.
REQ-013 start SHALL be ignored in every state except IDLE.
REQ-014 In READ, cycle k (k=0..len-1) SHALL drive in_en=1 and in_addr=(rd_base+k) mod 2^ADDR_W, registered.
REQ-015 After the last issue, the FSM SHALL go to DRAIN.
REQ-016 Read data SHALL be presented to the core RD_LAT cycles after its issue, through a valid/index pipeline of depth RD_LAT: ld_valid=1, ld_idx=k, ld_data=in_rddata.
REQ-017 ld_valid SHALL never be high for a word that was not issued.
REQ-018 DRAIN SHALL hold until the read pipeline is empty.
REQ-019 On leaving DRAIN, core_start SHALL pulse for exactly 1 cycle and the FSM SHALL enter PROC.
REQ-020 PROC SHALL wait for core_finish=1. core_finish SHALL be ignored outside PROC.
REQ-021 On core_finish in PROC, the FSM SHALL go to WRITE, or to FIN if wr_len==0.
REQ-022 WRITE SHALL hold counter j; st_idx=j combinationally from the registered counter.
REQ-023 At each WRITE edge: out_en<=1, out_we<=all ones, out_addr<=(wr_base+j) mod 2^ADDR_W, out_wrdata<=st_data. Each output word therefore appears 1 cycle after its st_idx.
REQ-024 After j==wr_len-1, the FSM SHALL go to FIN.
REQ-025 On the cycle after the last WRITE edge, out_en and out_we SHALL return to 0.
REQ-026 FIN SHALL pulse done for 1 cycle and return to IDLE.
REQ-027 Watchdog: when TO_CYC>0 and PROC has lasted TO_CYC cycles without core_finish, the block SHALL set err=1 and go to IDLE with no done pulse.
REQ-028 abort=1 in any non-IDLE state SHALL:
- move to IDLE on the next edge;
- deassert in_en, out_en, out_we, ld_valid and core_start on that edge;
- flush the read pipeline;
- set err=1;
- suppress done.
REQ-029 If abort and core_finish arrive in the same cycle, abort SHALL win.
REQ-030 If start and abort arrive in IDLE in the same cycle, the block SHALL start; abort has no effect in IDLE.
REQ-031 All counters SHALL be CNT_W bits; a len value of 2^CNT_W-1 SHALL transfer exactly that many words.
REQ-032 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-033 reg_rst SHALL force state IDLE and all outputs to 0: busy, done, err, in_*, ld_*, core_start, st_idx, out_*.
REQ-034 reg_rst SHALL clear all counters and the read pipeline, and it SHALL override start and abort.
REQ-035 Reset asserted mid-transaction SHALL discard the transaction, with no done pulse.

Verification
REQ-036 Scenario: RD_LAT=1; rd_base=52, rd_len=2, wr_base=102, wr_len=3; core_finish 10 cycles after core_start -> in_addr 52,53; ld_idx 0,1; one core_start pulse; out_addr 102,103,104 carrying st_data for st_idx 0,1,2; exactly one done pulse.
REQ-037 Scenario: RD_LAT=3; rd_len=4 -> ld_valid high for exactly 4 cycles, starting 3 cycles after the first in_en; core_start follows the last ld_valid.
REQ-038 Scenario: rd_base=254, rd_len=4, ADDR_W=8 -> in_addr sequence 254,255,0,1.
REQ-039 Scenario: abort during WRITE at j=1 -> IDLE on the next edge; out_en=0; err=1; no done. A subsequent start clears err.
REQ-040 Scenario: TO_CYC=16 with core_finish held 0 -> err=1 and busy=0 after 16 PROC cycles. Also: rd_len=0, wr_len=0 -> core_start pulse, then done, with no BRAM enables.
